// File: rtl/pc_redirect_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_redirect_ctrl_if
// Description : Bundle between the EX stage / hazard / trap logic and the
//               fetch-side PC redirect controller.
//               master : EX stage, hazard unit and trap handler (drive *_i,
//                        observe *_o)
//               slave  : pc_redirect_ctrl (observe *_i, drive *_o)
//               Ports:
//                 stall_i, ex_hold_i          freeze sequential fetch
//                 ex_valid_i, ex_branch_taken_i, ex_is_jal_i, ex_is_jalr_i
//                                             EX control-transfer resolution
//                 ex_branch_target_i          PC+imm for branch/JAL
//                 ex_jalr_target_i            rs1+imm for JALR
//                 trap_ack_i                  misaligned trap accepted
//                 pc_o, fetch_valid_o         fetch request
//                 flush_o                     squash IF/ID and ID/EX
//                 misaligned_o, bad_target_o  pending trap and its address
//                 redirect_cnt_o              saturating redirect count
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_redirect_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  stall_i;
  logic                  ex_valid_i;
  logic                  ex_branch_taken_i;
  logic                  ex_is_jalr_i;
  logic                  ex_is_jal_i;
  logic [DATA_WIDTH-1:0] ex_branch_target_i;
  logic [DATA_WIDTH-1:0] ex_jalr_target_i;
  logic                  ex_hold_i;
  logic                  trap_ack_i;
  logic [DATA_WIDTH-1:0] pc_o;
  logic                  fetch_valid_o;
  logic                  flush_o;
  logic                  misaligned_o;
  logic [DATA_WIDTH-1:0] bad_target_o;
  logic [15:0]           redirect_cnt_o;

  modport master (
    output stall_i, ex_valid_i, ex_branch_taken_i, ex_is_jalr_i, ex_is_jal_i,
           ex_branch_target_i, ex_jalr_target_i, ex_hold_i, trap_ack_i,
    input  pc_o, fetch_valid_o, flush_o, misaligned_o, bad_target_o,
           redirect_cnt_o
  );

  modport slave (
    input  stall_i, ex_valid_i, ex_branch_taken_i, ex_is_jalr_i, ex_is_jal_i,
           ex_branch_target_i, ex_jalr_target_i, ex_hold_i, trap_ack_i,
    output pc_o, fetch_valid_o, flush_o, misaligned_o, bad_target_o,
           redirect_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/pc_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pc_redirect_ctrl
// Description : Program-counter owner for an RV32IM pipeline. Advances the PC
//               sequentially, redirects on taken branch / JAL / JALR resolved
//               in EX, flushes the wrong-path instructions in IF/ID and ID/EX,
//               and holds fetch on a misaligned control-transfer target until
//               the trap handler acknowledges it.
//               Ports:
//                 clk    core clock, rising edge
//                 rst_n  asynchronous active-low reset
//                 bus    pc_redirect_ctrl_if.slave (see interface header)
// Revision    : 1.0 - initial release
// ============================================================================
module pc_redirect_ctrl #(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC     = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0] TRAP_VEC     = 32'h0000_0100,
  parameter int                    FLUSH_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  pc_redirect_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_TRAP  = 2'd2
  } state_e;

  localparam logic [2:0]            c_flush_init = 3'(FLUSH_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] c_pc_step    = DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-1:0] c_bit0_mask  = DATA_WIDTH'(1);
  localparam logic [15:0]           c_cnt_max    = 16'hFFFF;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic                  fetch_valid_q, fetch_valid_d;
  logic                  misaligned_q, misaligned_d;
  logic [DATA_WIDTH-1:0] bad_target_q, bad_target_d;
  logic [2:0]            flush_cnt_q, flush_cnt_d;
  logic [15:0]           redirect_cnt_q, redirect_cnt_d;

  logic                  w_redir;
  logic [DATA_WIDTH-1:0] w_target;
  logic                  w_target_misaligned;
  logic                  w_flush;

  // JALR clears bit0 of rs1+imm; without the C extension only bit1 can make
  // the resulting target misaligned.
  always_comb begin
    w_redir  = bus.ex_valid_i &
               (bus.ex_branch_taken_i | bus.ex_is_jal_i | bus.ex_is_jalr_i);
    w_target = bus.ex_is_jalr_i ? (bus.ex_jalr_target_i & ~c_bit0_mask)
                                : bus.ex_branch_target_i;
    w_target_misaligned = w_target[1];
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    misaligned_d   = misaligned_q;
    bad_target_d   = bad_target_q;
    flush_cnt_d    = flush_cnt_q;
    redirect_cnt_d = redirect_cnt_q;
    w_flush        = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (w_redir) begin
          // Redirect wins over stall/hold: the instructions behind it are
          // wrong-path, so freezing them would be pointless.
          w_flush = 1'b1;
          if (w_target_misaligned) begin
            bad_target_d = w_target;
            misaligned_d = 1'b1;
            state_d      = ST_TRAP;
          end else begin
            pc_d        = w_target;
            flush_cnt_d = c_flush_init;
            if (redirect_cnt_q != c_cnt_max) begin
              redirect_cnt_d = redirect_cnt_q + 16'd1;
            end
            state_d = (FLUSH_CYCLES == 1) ? ST_RUN : ST_FLUSH;
          end
        end else if (bus.stall_i | bus.ex_hold_i) begin
          pc_d = pc_q;
        end else if (fetch_valid_q) begin
          // Only step past an address that was actually presented as a valid
          // fetch; the first cycle out of reset must still fetch RESET_PC.
          pc_d = pc_q + c_pc_step;
        end
      end

      ST_FLUSH: begin
        // The redirect cycle itself already counted as one flush cycle.
        w_flush     = 1'b1;
        flush_cnt_d = flush_cnt_q - 3'd1;
        if (flush_cnt_q <= 3'd1) begin
          state_d = ST_RUN;
        end
      end

      ST_TRAP: begin
        w_flush = 1'b1;
        if (bus.trap_ack_i) begin
          pc_d         = TRAP_VEC;
          misaligned_d = 1'b0;
          state_d      = ST_RUN;
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase

    fetch_valid_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_RUN;
      pc_q           <= RESET_PC;
      fetch_valid_q  <= 1'b0;
      misaligned_q   <= 1'b0;
      bad_target_q   <= '0;
      flush_cnt_q    <= 3'd0;
      redirect_cnt_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      fetch_valid_q  <= fetch_valid_d;
      misaligned_q   <= misaligned_d;
      bad_target_q   <= bad_target_d;
      flush_cnt_q    <= flush_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  // flush_o is the only combinational output; it is gated by reset so the
  // pipeline is never squashed while the controller is held in reset.
  assign bus.flush_o        = rst_n & w_flush;
  assign bus.pc_o           = pc_q;
  assign bus.fetch_valid_o  = fetch_valid_q;
  assign bus.misaligned_o   = misaligned_q;
  assign bus.bad_target_o   = bad_target_q;
  assign bus.redirect_cnt_o = redirect_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_redirect_ctrl
// Description : Directed self-checking bench for pc_redirect_ctrl. Each step
//               drives the inputs, pushes the expected outputs for that cycle
//               into a scoreboard queue, then pops and compares on the
//               falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_redirect_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  pc_redirect_ctrl_if #(.DATA_WIDTH(32)) bus ();

  pc_redirect_ctrl #(
    .DATA_WIDTH   (32),
    .RESET_PC     (32'h0000_0000),
    .TRAP_VEC     (32'h0000_0100),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        fv;
    logic        fl;
    logic        mis;
    logic [31:0] bad;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic idle();
    bus.stall_i            = 1'b0;
    bus.ex_valid_i         = 1'b0;
    bus.ex_branch_taken_i  = 1'b0;
    bus.ex_is_jalr_i       = 1'b0;
    bus.ex_is_jal_i        = 1'b0;
    bus.ex_branch_target_i = 32'h0;
    bus.ex_jalr_target_i   = 32'h0;
    bus.ex_hold_i          = 1'b0;
    bus.trap_ack_i         = 1'b0;
  endtask

  task automatic branch(input logic [31:0] tgt);
    idle();
    bus.ex_valid_i         = 1'b1;
    bus.ex_branch_taken_i  = 1'b1;
    bus.ex_branch_target_i = tgt;
  endtask

  // One clock cycle: expectation pushed with the stimulus already applied,
  // checked at the falling edge, then advance to just after the next rise.
  task automatic cyc(input string tag, input logic [31:0] pc,
                     input logic fv, input logic fl, input logic mis,
                     input logic [31:0] bad, input logic [15:0] cnt);
    exp_t e;
    exp_t x;
    e.tag = tag; e.pc = pc; e.fv = fv; e.fl = fl;
    e.mis = mis; e.bad = bad; e.cnt = cnt;
    sb_q.push_back(e);
    @(negedge clk);
    x = sb_q.pop_front();
    n_cmp++;
    assert ({bus.pc_o, bus.fetch_valid_o, bus.flush_o, bus.misaligned_o,
             bus.bad_target_o, bus.redirect_cnt_o} ===
            {x.pc, x.fv, x.fl, x.mis, x.bad, x.cnt})
    else begin
      n_bad++;
      $error("FAIL %s: observed pc=%h fv=%b fl=%b mis=%b bad=%h cnt=%0d, expected pc=%h fv=%b fl=%b mis=%b bad=%h cnt=%0d",
             x.tag, bus.pc_o, bus.fetch_valid_o, bus.flush_o,
             bus.misaligned_o, bus.bad_target_o, bus.redirect_cnt_o,
             x.pc, x.fv, x.fl, x.mis, x.bad, x.cnt);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    @(posedge clk);
    #1;
    cyc("reset", 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 16'd0);

    // Release reset: first cycle still shows fetch_valid low.
    rst_n = 1'b1;
    cyc("post_rst", 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 16'd0);

    // Sequential fetch.
    cyc("seq_0",  32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 16'd0);
    cyc("seq_4",  32'h4, 1'b1, 1'b0, 1'b0, 32'h0, 16'd0);
    cyc("seq_8",  32'h8, 1'b1, 1'b0, 1'b0, 32'h0, 16'd0);
    cyc("seq_12", 32'hC, 1'b1, 1'b0, 1'b0, 32'h0, 16'd0);

    // Taken branch at 0x10 to 0x40: two flush cycles.
    branch(32'h40);
    cyc("br_issue", 32'h10, 1'b1, 1'b1, 1'b0, 32'h0, 16'd0);
    idle();
    cyc("br_flush", 32'h40, 1'b0, 1'b1, 1'b0, 32'h0, 16'd1);
    cyc("br_land",  32'h40, 1'b1, 1'b0, 1'b0, 32'h0, 16'd1);
    cyc("br_next",  32'h44, 1'b1, 1'b0, 1'b0, 32'h0, 16'd1);

    // JALR with odd target: bit0 dropped, no trap.
    idle();
    bus.ex_valid_i       = 1'b1;
    bus.ex_is_jalr_i     = 1'b1;
    bus.ex_jalr_target_i = 32'h0000_0081;
    cyc("jalr_issue", 32'h48, 1'b1, 1'b1, 1'b0, 32'h0, 16'd1);
    idle();
    cyc("jalr_flush", 32'h80, 1'b0, 1'b1, 1'b0, 32'h0, 16'd2);
    cyc("jalr_land",  32'h80, 1'b1, 1'b0, 1'b0, 32'h0, 16'd2);

    // Misaligned branch target traps; stall and EX inputs ignored in TRAP.
    branch(32'h42);
    cyc("mis_issue", 32'h84, 1'b1, 1'b1, 1'b0, 32'h0, 16'd2);
    branch(32'h300);
    bus.stall_i = 1'b1;
    cyc("trap_wait0", 32'h84, 1'b0, 1'b1, 1'b1, 32'h42, 16'd2);
    cyc("trap_wait1", 32'h84, 1'b0, 1'b1, 1'b1, 32'h42, 16'd2);
    idle();
    bus.trap_ack_i = 1'b1;
    cyc("trap_ack", 32'h84, 1'b0, 1'b1, 1'b1, 32'h42, 16'd2);
    idle();
    cyc("trap_vec", 32'h100, 1'b1, 1'b0, 1'b0, 32'h42, 16'd2);

    // Redirect beats stall; a branch during FLUSH is ignored.
    branch(32'h200);
    bus.stall_i = 1'b1;
    cyc("stall_br", 32'h104, 1'b1, 1'b1, 1'b0, 32'h42, 16'd2);
    branch(32'h500);
    cyc("flush_ignore", 32'h200, 1'b0, 1'b1, 1'b0, 32'h42, 16'd3);
    idle();
    cyc("stall_land", 32'h200, 1'b1, 1'b0, 1'b0, 32'h42, 16'd3);

    // Stall alone holds for three cycles, then ex_hold alone for one.
    bus.stall_i = 1'b1;
    cyc("stall_0", 32'h204, 1'b1, 1'b0, 1'b0, 32'h42, 16'd3);
    cyc("stall_1", 32'h204, 1'b1, 1'b0, 1'b0, 32'h42, 16'd3);
    cyc("stall_2", 32'h204, 1'b1, 1'b0, 1'b0, 32'h42, 16'd3);
    idle();
    cyc("stall_rel", 32'h204, 1'b1, 1'b0, 1'b0, 32'h42, 16'd3);
    bus.ex_hold_i = 1'b1;
    cyc("hold_0", 32'h208, 1'b1, 1'b0, 1'b0, 32'h42, 16'd3);
    idle();
    cyc("hold_rel", 32'h208, 1'b1, 1'b0, 1'b0, 32'h42, 16'd3);

    // Reset asserted in the middle of FLUSH.
    branch(32'h400);
    cyc("rf_issue", 32'h20C, 1'b1, 1'b1, 1'b0, 32'h42, 16'd3);
    idle();
    #1;
    rst_n = 1'b0;
    cyc("rst_mid_flush", 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 16'd0);
    rst_n = 1'b1;
    cyc("rst_rel", 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 16'd0);

    // JAL near the top of the address space, then wrap to zero.
    idle();
    bus.ex_valid_i         = 1'b1;
    bus.ex_is_jal_i        = 1'b1;
    bus.ex_branch_target_i = 32'hFFFF_FFF8;
    cyc("jal_issue", 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 16'd0);
    idle();
    cyc("jal_flush", 32'hFFFF_FFF8, 1'b0, 1'b1, 1'b0, 32'h0, 16'd1);
    cyc("wrap_m8",   32'hFFFF_FFF8, 1'b1, 1'b0, 1'b0, 32'h0, 16'd1);
    cyc("wrap_m4",   32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 32'h0, 16'd1);
    cyc("wrap_0",    32'h0,         1'b1, 1'b0, 1'b0, 32'h0, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
- Fetch-side partner of the RV32IM execute-stage ALU.
- Consumes the EX stage's branch/JALR resolution (branch taken, JALR target, hold request), owns the program counter, and issues pipeline flushes for wrong-path instructions.
- Sits between the ALU outputs and the IF/ID and ID/EX pipeline registers.
- Also detects misaligned control-transfer targets and holds fetch until the trap is acknowledged.

Parameters:
- DATA_WIDTH, 32, width of PC and target buses
- RESET_PC, 32'h0000_0000, PC value loaded at reset
- TRAP_VEC, 32'h0000_0100, PC loaded after a misaligned-target trap is acknowledged
- FLUSH_CYCLES, 2, number of cycles flush_o stays high per redirect (legal range 1..7)

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stall_i  in  1  load-use/hold stall from hazard logic; freezes PC
- ex_valid_i  in  1  EX stage holds a valid instruction this cycle
- ex_branch_taken_i  in  1  conditional branch resolved taken
- ex_is_jalr_i  in  1  EX instruction is JALR
- ex_is_jal_i  in  1  EX instruction is JAL
- ex_branch_target_i  in  DATA_WIDTH  PC+imm for branch/JAL
- ex_jalr_target_i  in  DATA_WIDTH  rs1+imm from ALU
- ex_hold_i  in  1  ALU hold_pipeline request; treated as stall
- trap_ack_i  in  1  trap handler accepts misaligned trap
- pc_o  out  DATA_WIDTH  current fetch address
- fetch_valid_o  out  1  pc_o is a valid fetch request
- flush_o  out  1  squash IF/ID and ID/EX contents
- misaligned_o  out  1  misaligned-target trap pending
- bad_target_o  out  DATA_WIDTH  offending target address
- redirect_cnt_o  out  16  count of taken redirects, saturating

Behaviour:
- Reset (async, rst_n=0): state=RUN, pc_o=RESET_PC, fetch_valid_o=0, flush_o=0, misaligned_o=0, bad_target_o=0, redirect_cnt_o=0. fetch_valid_o rises in the first cycle after rst_n deasserts.
- States: RUN, FLUSH, TRAP.
- Redirect request: redir = ex_valid_i & (ex_branch_taken_i | ex_is_jal_i | ex_is_jalr_i).
- Target selection:
  - JALR: ex_jalr_target_i with bit0 forced to 0.
  - Otherwise: ex_branch_target_i.
  - Misaligned when selected target bit1 = 1. RV32IM has no C extension, so only bit1 matters.
- RUN:
  - redir and target aligned: flush_o=1 combinationally in the same cycle. Next edge: pc_o<=target, counter<=FLUSH_CYCLES-1, redirect_cnt_o++ (saturates at 16'hFFFF). Go to FLUSH, or stay in RUN if FLUSH_CYCLES==1.
  - redir and target misaligned: flush_o=1 this cycle. Next edge: bad_target_o<=target, misaligned_o<=1, go to TRAP, pc_o unchanged.
  - No redir and (stall_i | ex_hold_i): pc_o holds, fetch_valid_o stays 1.
  - Otherwise: pc_o<=pc_o+4, modulo 2^32 wrap (32'hFFFF_FFFC -> 0).
  - Redirect has priority over stall and hold in the same cycle.
  - fetch_valid_o = 1.
- FLUSH:
  - flush_o=1, fetch_valid_o=0, pc_o holds target.
  - All ex_* inputs are ignored (wrong-path instructions).
  - Counter decrements each cycle; at 0, go to RUN.
  - flush_o is high for exactly FLUSH_CYCLES consecutive cycles per redirect.
  - The first RUN cycle after FLUSH presents pc_o=target with fetch_valid_o=1.
- TRAP:
  - fetch_valid_o=0, flush_o=1, misaligned_o=1; ex_* and stall_i are ignored.
  - trap_ack_i=1: next edge pc_o<=TRAP_VEC, misaligned_o<=0, go to RUN. bad_target_o holds until the next trap.
- Reset asserted in any state returns immediately to reset values, including mid-FLUSH and mid-TRAP.
- All outputs except flush_o are registered.

Test Plan:
- Sequential fetch: reset release with RESET_PC=0, no stimulus for 4 cycles -> pc_o = 0,4,8,12, fetch_valid_o=1, flush_o=0.
- Taken branch: at pc=0x10, ex_valid=1, ex_branch_taken=1, target=0x40 -> flush_o high in that cycle plus 1 more cycle (2 total). Next pc_o=0x40 with fetch_valid_o=0, then 0x40 with fetch_valid_o=1, then 0x44. redirect_cnt_o=1.
- JALR with odd target: ex_is_jalr=1, ex_jalr_target=0x0000_0081 -> pc_o=0x80 after the flush, no trap.
- Misaligned branch: target=0x0000_0042 -> misaligned_o=1, bad_target_o=0x42, fetch_valid_o=0 until trap_ack_i. After ack, pc_o=0x100 and misaligned_o=0.
- Redirect vs stall: stall_i=1 with a taken branch to 0x200 in the same cycle -> redirect wins, pc_o=0x200. Stall alone holds pc_o for 3 cycles. A second branch arriving during FLUSH is ignored and redirect_cnt_o is unchanged.
- Reset mid-FLUSH and wrap-around: rst_n low during FLUSH -> pc_o=RESET_PC, flush_o=0 immediately. Separately, pc=0xFFFF_FFFC with no stall -> next pc_o=0x0.
